fifo_rd_stream: RTL and testbench

// - Read-side consumer for the async FIFO, in the rd_clk domain.
// - Watches the registered rd_empty flag and drives rd_inc to pop words.
// - Captures the 1-cycle-latency memory read data into a small prefetch/skid buffer.
// - Presents that data downstream as a valid/ready stream (m_valid/m_ready/m_data).
// - Sits between the read-pointer/empty logic plus the dual-port memory and the read-domain client.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_skid_buf.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 88 ++++++++
 tb/tb_fifo_rd_stream.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address/data widths and the word type.
package fifo_pkg;

   localparam int unsigned ADDR_SIZE = 4;
   localparam int unsigned DATA_SIZE = 8;

   typedef logic [DATA_SIZE-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_skid_buf.sv
// DEPTH-entry circular prefetch buffer; head entry is always visible on rd_data.
// Pointers wrap explicitly at DEPTH so non-power-of-2 depths are legal.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = DATA_SIZE,
   localparam int unsigned CNT_B = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic             clr,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_B-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             do_wr;
   logic             do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A write into a full buffer is only accepted when the head leaves the same cycle.
   assign do_rd   = rd_en && (count != '0);
   assign do_wr   = wr_en && ((count != CNT_B'(DEPTH)) || do_rd);
   assign rd_data = mem[head];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         mem   <= '{default: '0};
      end else if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_wr) begin
            mem[tail] <= wr_data;
            tail      <= ptr_inc(tail);
         end
         if (do_rd) begin
            head <= ptr_inc(head);
         end
         if (do_wr && !do_rd) begin
            count <= count + CNT_B'(1);
         end else if (do_rd && !do_wr) begin
            count <= count - CNT_B'(1);
         end
      end
   end

endmodule : fifo_skid_buf

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops words via rd_inc and streams them out as valid/ready.
// Optional delivery/stall statistics counters are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_SIZE = fifo_pkg::DATA_SIZE,
   parameter int unsigned DEPTH     = 3
`ifdef FIFO_RD_STATS_EN
   ,
   parameter int unsigned CNT_W     = 16
`endif
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 rd_empty,
   input  logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_inc,
   input  logic                 rd_flush,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_SIZE-1:0] m_data
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [CNT_W-1:0]     rd_pop_cnt,
   output logic [CNT_W-1:0]     rd_stall_cnt
`endif
);

   localparam int unsigned CNT_B = $clog2(DEPTH + 1);
   localparam int unsigned LVL_W = CNT_B + 1;

   logic [CNT_B-1:0] count;
   logic [LVL_W-1:0] level;
   logic             inflight;
   logic             drop;
   logic             wr_en;
   logic             xfer;

   // Buffered plus in-flight words; issue only while a slot is guaranteed.
   assign level  = {1'b0, count} + {{CNT_B{1'b0}}, inflight};
   assign rd_inc = rd_rst && !rd_empty && !rd_flush && (level < LVL_W'(DEPTH));

   assign m_valid = (count != '0);
   assign xfer    = m_valid && m_ready;
   assign wr_en   = inflight && !drop;

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         inflight <= rd_inc;
         drop     <= rd_flush;
      end
   end

   fifo_skid_buf #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_SIZE)
   ) u_skid (
      .clk     (rd_clk),
      .rst     (rd_rst),
      .wr_en   (wr_en),
      .wr_data (rd_data),
      .rd_en   (xfer),
      .clr     (rd_flush),
      .rd_data (m_data),
      .count   (count)
   );

`ifdef FIFO_RD_STATS_EN
   // Saturating counters; survive rd_flush, cleared only by reset.
   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         rd_pop_cnt   <= '0;
         rd_stall_cnt <= '0;
      end else begin
         if (xfer && (rd_pop_cnt != '1)) begin
            rd_pop_cnt <= rd_pop_cnt + CNT_W'(1);
         end
         if (m_ready && !m_valid && (rd_stall_cnt != '1)) begin
            rd_stall_cnt <= rd_stall_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule : fifo_rd_stream

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural read-side FIFO source model.
// Statistics checks are compiled in when FIFO_RD_STATS_EN is defined.
module tb_fifo_rd_stream;
   import fifo_pkg::*;

   logic        rd_clk = 1'b0;
   logic        rd_rst;
   logic        rd_empty = 1'b1;
   logic [7:0]  rd_data  = 8'h00;
   logic        rd_inc;
   logic        rd_flush;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
`ifdef FIFO_RD_STATS_EN
   logic [15:0] rd_pop_cnt;
   logic [15:0] rd_stall_cnt;
`endif

   int unsigned loaded = 0;
   int unsigned popped = 0;
   int          checks = 0;
   int          errors = 0;
   int          pulses;
   int          xfers;

   fifo_rd_stream dut (
      .rd_clk   (rd_clk),
      .rd_rst   (rd_rst),
      .rd_empty (rd_empty),
      .rd_data  (rd_data),
      .rd_inc   (rd_inc),
      .rd_flush (rd_flush),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data)
`ifdef FIFO_RD_STATS_EN
      ,
      .rd_pop_cnt   (rd_pop_cnt),
      .rd_stall_cnt (rd_stall_cnt)
`endif
   );

   always #5 rd_clk = ~rd_clk;

   // Source: word k popped carries 0x10+k, returned one cycle after rd_inc; empty flag registered.
   always @(posedge rd_clk) begin
      if (rd_inc) begin
         rd_data <= 8'(32'h10 + popped);
         popped  <= popped + 1;
      end
      rd_empty <= (loaded == popped + 32'(rd_inc));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_rst   = 1'b0;
      rd_flush = 1'b0;
      m_ready  = 1'b1;
      loaded   = 8;

      // Reset held with a non-empty source
      repeat (3) @(negedge rd_clk);
      check("rst_inc", 32'(rd_inc), 0);
      check("rst_valid", 32'(m_valid), 0);
      check("rst_data", 32'(m_data), 0);
      rd_rst = 1'b1;
      #1 check("rel_inc", 32'(rd_inc), 1);

      // Streaming 0x10..0x17, two-cycle latency, no bubbles
      @(negedge rd_clk);
      check("lat_valid0", 32'(m_valid), 0);
      @(negedge rd_clk);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("strm_valid%0d", i), 32'(m_valid), 1);
         check($sformatf("strm_data%0d", i), 32'(m_data), 32'(word_t'(32'h10 + i)));
         @(negedge rd_clk);
      end
      check("strm_end_valid", 32'(m_valid), 0);
      check("strm_end_inc", 32'(rd_inc), 0);

      // Backpressure: exactly DEPTH pops, head held, then in-order drain
      m_ready = 1'b0;
      loaded  = loaded + 8;
      pulses  = 0;
      repeat (10) begin
         @(negedge rd_clk);
         if (rd_inc) pulses++;
      end
      check("bp_pulses", 32'(pulses), 3);
      check("bp_valid", 32'(m_valid), 1);
      check("bp_head", 32'(m_data), 32'h18);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_data%0d", i), 32'(m_data), 32'(word_t'(32'h18 + i)));
         @(negedge rd_clk);
      end
      check("bp_end_valid", 32'(m_valid), 0);

      // Flush with two buffered words and one in flight, coinciding with a transfer
      m_ready = 1'b0;
      loaded  = loaded + 8;
      pulses  = 0;
      for (int k = 0; k < 20 && pulses < 3; k++) begin
         @(negedge rd_clk);
         if (rd_inc) pulses++;
      end
      check("fl_pulses", 32'(pulses), 3);
      @(negedge rd_clk);
      check("fl_pre_valid", 32'(m_valid), 1);
      check("fl_pre_inc", 32'(rd_inc), 0);
      check("fl_pre_head", 32'(m_data), 32'h20);
      rd_flush = 1'b1;
      m_ready  = 1'b1;
      #1 check("fl_inc_forced", 32'(rd_inc), 0);
      @(negedge rd_clk);
      rd_flush = 1'b0;
      check("fl_valid", 32'(m_valid), 0);
      for (int k = 0; k < 10 && !m_valid; k++) @(negedge rd_clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("fl_valid%0d", i), 32'(m_valid), 1);
         check($sformatf("fl_data%0d", i), 32'(m_data), 32'(word_t'(32'h23 + i)));
         @(negedge rd_clk);
      end
      check("fl_end_valid", 32'(m_valid), 0);

      // Asynchronous reset in the middle of buffered data
      m_ready = 1'b0;
      loaded  = loaded + 3;
      repeat (8) @(negedge rd_clk);
      check("mr_valid", 32'(m_valid), 1);
      check("mr_head", 32'(m_data), 32'h28);
      #2 rd_rst = 1'b0;
      #1;
      check("mr_rst_valid", 32'(m_valid), 0);
      check("mr_rst_inc", 32'(rd_inc), 0);
      check("mr_rst_data", 32'(m_data), 0);
      @(negedge rd_clk);
      rd_rst = 1'b1;
      #1 check("mr_empty_inc", 32'(rd_inc), 0);
`ifdef FIFO_RD_STATS_EN
      check("st_pop_rst", 32'(rd_pop_cnt), 0);
      check("st_stall_rst", 32'(rd_stall_cnt), 0);
`endif

      // Four starved cycles, then five transfers
      m_ready = 1'b1;
      repeat (4) @(negedge rd_clk);
      m_ready = 1'b0;
      loaded  = loaded + 5;
      repeat (10) @(negedge rd_clk);
      m_ready = 1'b1;
      xfers   = 0;
      for (int k = 0; k < 20 && xfers < 5; k++) begin
         if (m_valid) begin
            check($sformatf("st_data%0d", xfers), 32'(m_data), 32'(word_t'(32'h2B + xfers)));
            xfers++;
         end
         @(negedge rd_clk);
      end
      m_ready = 1'b0;
      check("st_xfers", 32'(xfers), 5);
`ifdef FIFO_RD_STATS_EN
      check("st_pop", 32'(rd_pop_cnt), 5);
      check("st_stall", 32'(rd_stall_cnt), 4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fifo_rd_stream
